// File: rtl/aukv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package aukv_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [2:0] MULDIV_MUL    = 3'd0;
    localparam logic [2:0] MULDIV_MULH   = 3'd1;
    localparam logic [2:0] MULDIV_MULHSU = 3'd2;
    localparam logic [2:0] MULDIV_MULHU  = 3'd3;
    localparam logic [2:0] MULDIV_DIV    = 3'd4;
    localparam logic [2:0] MULDIV_DIVU   = 3'd5;
    localparam logic [2:0] MULDIV_REM    = 3'd6;
    localparam logic [2:0] MULDIV_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

endpackage

// File: rtl/aukv_muldiv_step.sv
// One radix-2 step: shift-add for multiply, restoring trial-subtract for divide.
module aukv_muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic                is_div,
    input  logic [2*XLEN-1:0]   acc,
    input  logic [XLEN-1:0]     opb,
    output logic [2*XLEN-1:0]   acc_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    always_comb begin
        sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
        // Divide: {remainder, next dividend bit} against the divisor.
        shifted = acc[2*XLEN-1:XLEN-1];
        trial   = shifted - {1'b0, opb};
        if (is_div) begin
            if (trial[XLEN]) begin
                acc_nxt = {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                acc_nxt = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            end
        end else begin
            acc_nxt = {sum, acc[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/aukv_muldiv.sv
// Iterative RV32M multiply/divide unit: FSM, counter, sign handling and handshake.
// IDLE accept | BUSY one step per cycle | FIX sign fixup, select result | DONE hold result
module aukv_muldiv
    import aukv_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int TAGW = 5
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_flush,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [TAGW-1:0] i_tag,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [XLEN-1:0] o_rd,
    output logic [TAGW-1:0] o_tag
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN-1);

    muldiv_state_e      state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [TAGW-1:0]    tag_q, tag_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [XLEN-1:0]    opb_q, opb_d;
    logic [2*XLEN-1:0]  acc_q, acc_d;
    logic [XLEN-1:0]    rd_q, rd_d;
    logic [TAGW-1:0]    otag_q, otag_d;

    logic [2*XLEN-1:0]  acc_step;
    logic               sa, sb;
    logic [XLEN-1:0]    ma, mb;
    logic               div_zero, div_ovf;
    logic [2*XLEN-1:0]  prod_f;
    logic [XLEN-1:0]    quo_f, rem_f;

    aukv_muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_q[2]),
        .acc     (acc_q),
        .opb     (opb_q),
        .acc_nxt (acc_step)
    );

    always_comb begin
        sa = ((i_op == MULDIV_MULH) || (i_op == MULDIV_MULHSU) ||
              (i_op == MULDIV_DIV)  || (i_op == MULDIV_REM)) && i_rs1[XLEN-1];
        sb = ((i_op == MULDIV_MULH) || (i_op == MULDIV_DIV) ||
              (i_op == MULDIV_REM)) && i_rs2[XLEN-1];
        ma = sa ? -i_rs1 : i_rs1;
        mb = sb ? -i_rs2 : i_rs2;
        div_zero = i_op[2] && (i_rs2 == '0);
        div_ovf  = ((i_op == MULDIV_DIV) || (i_op == MULDIV_REM)) &&
                   (i_rs1 == MIN_INT) && (i_rs2 == '1);

        prod_f = neg_q ? -acc_q : acc_q;
        quo_f  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_f  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        rd_d    = rd_q;
        otag_d  = otag_q;

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    op_d  = i_op;
                    tag_d = i_tag;
                    neg_d = (i_op == MULDIV_REM) ? sa : (sa ^ sb);
                    if (i_op[2]) begin
                        acc_d = {{XLEN{1'b0}}, ma};
                        opb_d = mb;
                    end else begin
                        acc_d = {{XLEN{1'b0}}, mb};
                        opb_d = ma;
                    end
                    if (div_zero || div_ovf) begin
                        // Results that never touch the datapath.
                        otag_d  = i_tag;
                        state_d = ST_DONE;
                        if (div_zero) begin
                            rd_d = i_op[1] ? i_rs1 : '1;
                        end else begin
                            rd_d = i_op[1] ? '0 : i_rs1;
                        end
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                acc_d = acc_step;
                if (cnt_q == '0) begin
                    state_d = ST_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_FIX: begin
                case (op_q)
                    MULDIV_MUL:                rd_d = prod_f[XLEN-1:0];
                    MULDIV_DIV, MULDIV_DIVU:   rd_d = quo_f;
                    MULDIV_REM, MULDIV_REMU:   rd_d = rem_f;
                    default:                   rd_d = prod_f[2*XLEN-1:XLEN];
                endcase
                otag_d  = tag_q;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (o_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            op_d    = op_q;
            tag_d   = tag_q;
            neg_d   = neg_q;
            opb_d   = opb_q;
            acc_d   = acc_q;
            rd_d    = rd_q;
            otag_d  = otag_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            opb_q   <= '0;
            acc_q   <= '0;
            rd_q    <= '0;
            otag_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            rd_q    <= rd_d;
            otag_q  <= otag_d;
        end
    end

    assign i_ready = (state_q == ST_IDLE);
    assign o_valid = (state_q == ST_DONE);
    assign o_rd    = rd_q;
    assign o_tag   = otag_q;

endmodule

// File: tb/tb_aukv_muldiv.sv
// Randomised and directed bench for aukv_muldiv against an arithmetic reference model.
module tb_aukv_muldiv;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic [4:0]  tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rd;
    logic [4:0]  rtag;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    aukv_muldiv #(.XLEN(32), .TAGW(5)) dut (
        .i_clk   (clk),
        .i_rstn  (rstn),
        .i_flush (flush),
        .i_valid (in_valid),
        .i_ready (in_ready),
        .i_op    (op),
        .i_rs1   (rs1),
        .i_rs2   (rs2),
        .i_tag   (tag),
        .o_valid (out_valid),
        .o_ready (out_ready),
        .o_rd    (rd),
        .o_tag   (rtag)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", name, obs, exp);
    endtask

    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int q;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                q = $signed(a) / $signed(b);
                return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                q = $signed(a) % $signed(b);
                return q;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Issue one op, check latency, result and tag, optionally stall the consumer, then release.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] t, input int hold);
        int lat;
        logic busy_rdy;
        logic moved;
        logic [31:0] rd0;
        logic [4:0]  tag0;
        @(negedge clk);
        chk("ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1; op = f; rs1 = a; rs2 = b; tag = t;
        @(posedge clk); #1;
        in_valid = 1'b0; rs1 = $urandom; rs2 = $urandom; tag = 5'($urandom);
        op = 3'($urandom);
        lat = 1; busy_rdy = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_rdy = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("latency op%0d", f), 64'(lat), 64'(ref_lat(f, a, b)));
        chk($sformatf("rd op%0d %h %h", f, a, b), 64'(rd), 64'(ref_op(f, a, b)));
        chk("tag", 64'(rtag), 64'(t));
        if (lat > 1) chk("ready_low_busy", 64'(busy_rdy), 64'd0);
        if (hold > 0) begin
            rd0 = rd; tag0 = rtag; moved = 1'b0;
            repeat (hold) begin
                @(posedge clk); #1;
                if (!out_valid || rd !== rd0 || rtag !== tag0) moved = 1'b1;
            end
            chk("backpressure_stable", 64'(moved), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_valid", 64'(out_valid), 64'd0);
        chk("release_ready", 64'(in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; rs1 = '0; rs2 = '0; tag = '0;
        #12;
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_tag", 64'(rtag), 64'd0);
        @(negedge clk); rstn = 1'b1;

        run_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 0);
        run_op(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd2, 0);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 5'd5, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 5'd6, 0);
        run_op(3'd5, 32'hFFFF_FFFF, 32'h0000_0002, 5'd7, 0);
        run_op(3'd7, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8, 0);
        run_op(3'd4, 32'h0000_1234, 32'h0000_0000, 5'd9, 0);
        run_op(3'd7, 32'h0000_0005, 32'h0000_0000, 5'd10, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);
        run_op(3'd0, 32'h0001_0003, 32'h0000_0011, 5'h13, 10);
        run_op(3'd4, 32'h0000_0000, 32'h0000_0000, 5'h14, 10);

        // Flush in the middle of BUSY.
        @(negedge clk);
        in_valid = 1'b1; op = 3'd0; rs1 = 32'h1234_5678; rs2 = 32'h9ABC_DEF0; tag = 5'd21;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        chk("flush_ready", 64'(in_ready), 64'd1);
        chk("flush_valid", 64'(out_valid), 64'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("flush_no_result", 64'(seen), 64'd0);
        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 5'd22, 0);

        // Flush together with a request in IDLE must not accept it.
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; op = 3'd4; rs1 = 32'd5; rs2 = 32'd0; tag = 5'd23;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_accept_ready", 64'(in_ready), 64'd1);
        chk("flush_accept_valid", 64'(out_valid), 64'd0);

        // Async reset in the middle of BUSY.
        @(negedge clk);
        in_valid = 1'b1; op = 3'd1; rs1 = 32'h7654_3210; rs2 = 32'h0F0F_0F0F; tag = 5'd24;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_rd", 64'(rd), 64'd0);
        chk("midrst_tag", 64'(rtag), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);
        @(negedge clk); rstn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst_no_result", 64'(seen), 64'd0);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'($urandom_range(0, 255));
                default: ;
            endcase
            run_op(rf, ra, rb, 5'($urandom), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/aukv_muldiv.md
Name: aukv_muldiv

Overview:
- Iterative RV32M multiply/divide unit. It is the parametrised successor of the single-cycle integer ALU.
- Sits in the EX stage beside the ALU. EX stalls on i_ready/o_valid while an M-extension instruction is in flight.
- Radix-2 shift-add multiplier and restoring divider share one datapath. Width is parametrised and a tag rides alongside each operation.

Parameters:
- XLEN, 32, operand/result width; must be >= 4 and a power of 2.
- TAGW, 5, width of the destination-register tag carried alongside the op.

Ports:
- i_clk  in  1  clock
- i_rstn  in  1  reset
- i_flush  in  1  abandon in-flight op (pipeline flush)
- i_valid  in  1  request valid
- i_ready  out  1  unit can accept a request
- i_op  in  3  funct3 encoding: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- i_rs1  in  XLEN  operand A
- i_rs2  in  XLEN  operand B
- i_tag  in  TAGW  destination tag
- o_valid  out  1  result valid
- o_ready  in  1  consumer accepts result
- o_rd  out  XLEN  result
- o_tag  out  TAGW  tag of result

Interface (already decided): one clock, i_clk; reset i_rstn is asynchronous and active-low.

Behaviour:
- Reset (async, i_rstn=0): state=IDLE, i_ready=1, o_valid=0, o_rd=0, o_tag=0, counter=0, all datapath registers 0.
- States are IDLE, BUSY, FIX, DONE.
- i_ready=1 only in IDLE. A request is accepted on a rising edge with i_valid&i_ready.
- IDLE, on accept: latch op and tag.
  - Signed ops: MULH/DIV/REM sign both operands; MULHSU signs rs1 only. Convert signed operands to magnitudes and record the result sign.
  - Special cases go to DONE directly (o_valid one cycle after accept):
    - DIV/DIVU with rs2=0: result all-ones.
    - REM/REMU with rs2=0: result rs1.
    - DIV with rs1=-2^(XLEN-1) and rs2=-1: result rs1.
    - REM with the same operands: result 0.
  - Otherwise go to BUSY with counter=XLEN-1.
- BUSY: one radix-2 step per cycle; counter decrements; at counter==0 go to FIX. BUSY occupies exactly XLEN cycles.
  - Multiply: 2*XLEN product register.
  - Divide: XLEN remainder register plus quotient shift register.
- FIX (one cycle): two's-complement negate if sign is set, then select the result:
  - MUL: low half of the product.
  - MULH/MULHSU/MULHU: high half.
  - DIV/DIVU: quotient. Sign = rs1 xor rs2, not applied for DIVU.
  - REM/REMU: remainder. Sign = sign of rs1.
  - Register o_rd/o_tag, then go to DONE.
- DONE: o_valid=1. o_rd/o_tag are held stable until o_ready=1, at which edge the unit goes to IDLE and o_valid drops. There is no back-to-back accept in the same edge.
- Latency: normal op gives o_valid XLEN+2 edges after the accepting edge (34 for XLEN=32). Special case gives 1 edge.
- i_flush=1 in any state: next state IDLE, o_valid=0, counter=0; the output result is discarded. Flush has priority over accept and over the DONE handshake.
- Flush and i_valid together in IDLE: request not accepted.
- Operands changing after accept have no effect.
- Async reset mid-operation: immediate return to reset values; no result is emitted.
- All arithmetic is modulo 2^XLEN; the product is kept at full 2*XLEN width internally.

Decomposition:
- Shared package aukv_pkg: op-code localparams (MULDIV_MUL…MULDIV_REMU), state encoding localparams, XLEN default.
- One natural sub-module: aukv_muldiv_step, a combinational single radix-2 step.
  - Multiply: conditional add + shift.
  - Divide: trial subtract + shift + quotient bit.
  - aukv_muldiv instantiates it once, with the FSM, counter, sign handling and handshake.

Test Plan (XLEN=32):
- MUL 7×(-3) (0x00000007, 0xFFFFFFFD) → o_rd=0xFFFFFFEB, o_valid exactly 34 edges after accept, i_ready=0 throughout.
- MULH/MULHSU/MULHU with rs1=0x80000000, rs2=0xFFFFFFFF → 0x00000000, 0x80000000, 0x7FFFFFFF respectively.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF; REMU 0xFFFFFFFF/2 → 0x00000001.
- Corner cases, each with o_valid one edge after accept:
  - DIV by 0 → 0xFFFFFFFF.
  - REMU 5/0 → 0x00000005.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Backpressure: hold o_ready=0 for 10 cycles in DONE → o_valid, o_rd, o_tag stable; o_ready=1 → IDLE next edge with i_ready=1. Tag 0x13 in → o_tag=0x13.
- Abort paths:
  - i_flush pulse at BUSY cycle 12 → IDLE next edge, no o_valid; following MULHU accepted and correct.
  - i_rstn low mid-BUSY → all outputs 0 immediately.
